mc_sequencer: RTL
=================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MUL_CYCLES, default 4, SHALL set the MUL execute length in cycles (legal 1..15).
REQ-002 CLOCK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RESET_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 instruction  in  32  SHALL be the memory read data; it is captured only in FETCH. Opcode is [31:26], funct is [5:0].
REQ-005 zero, alu_neg  in  1 each  SHALL be the datapath ALU result-zero and result-negative flags.
REQ-006 mem_ready  in  1  SHALL be the memory completion strobe.
REQ-007 mem_req, mem_we  out  1 each  SHALL be the memory access request and write qualifier.
REQ-008 pc_write, ir_write, reg_write  out  1 each  SHALL be the datapath register write strobes.
REQ-009 pc_src  out  2  SHALL select the next PC: 0 PC+4, 1 branch target, 2 jump target, 3 rs.
REQ-010 reg_dst, wb_sel  out  2 each  SHALL be the destination select (0 rt, 1 rd, 2 r31) and write-back select (0 ALU, 1 mem, 2 PC+4).
REQ-011 alu_src_b  out  1  SHALL select the ALU B operand: 0 register, 1 immediate.
REQ-012 ALU  out  5  SHALL be the ALU control code: ADD 00000, SLL 00001, SUB 00010, AND 00011, OR 00100, NOR 00101, SLT 00110, SRL 00111, SRA 01000, MUL 01001, LUI 01010.
REQ-013 illegal  out  1  SHALL be a one-cycle pulse flagging an undecoded instruction.

Function
REQ-014 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, MULW. Outputs are Moore-decoded from the state and the latched opcode/funct.
REQ-015 FETCH:
- mem_req=1, mem_we=0.
- The FSM holds while mem_ready=0.
- In the cycle mem_ready=1: ir_write=1, pc_write=1, pc_src=0; opcode/funct are latched; the FSM goes to DECODE.
REQ-016 DECODE (1 cycle) SHALL route by instruction class:
- R-type ALU, shifts, lw/sw, I-type ALU, lui -> EXEC
- beq/bne/bgez/bgtz -> BRANCH
- j/jal/jr -> JUMP
- mul -> MULW
- anything else -> illegal=1, then FETCH with no write strobe.
REQ-017 EXEC (1 cycle) SHALL drive ALU and alu_src_b (1 for I-type, lw, sw), then go to MEM for lw/sw and to WB otherwise.
REQ-018 MEM SHALL assert mem_req, with mem_we=1 for sw.
- It holds until mem_ready=1.
- Then lw goes to WB and sw goes to FETCH.
REQ-019 WB (1 cycle) SHALL assert reg_write with reg_dst=1 for R-type and 0 otherwise, wb_sel=1 for lw and 0 otherwise, then go to FETCH.
REQ-020 BRANCH (1 cycle) SHALL drive ALU=SUB.
- pc_write=1 and pc_src=1 when taken; otherwise no strobe.
- Taken: beq zero; bne !zero; bgez !alu_neg; bgtz !alu_neg&&!zero.
- Then FETCH.
REQ-021 JUMP (1 cycle) SHALL assert pc_write=1, then go to FETCH.
- j: pc_src=2.
- jal: pc_src=2, plus reg_write=1, reg_dst=2, wb_sel=2.
- jr: pc_src=3.
REQ-022 Zero-wait latency SHALL be: R-type/I-type 4 cycles, lw 5, sw 4, branch/jump 3, mul 3+MUL_CYCLES, each fetch to fetch.
REQ-023 mem_ready SHALL be ignored whenever mem_req=0. mem_req SHALL stay high, with address/qualifiers stable, until the cycle mem_ready=1.
REQ-024 sll with all-zero instruction (no-op) SHALL follow the R-type path with reg_write=0 in WB.

Reset
REQ-025 RESET_N low SHALL immediately force state FETCH, latched opcode/funct to 0, and every strobe, illegal and ALU output to 0, including mid-access or mid-MULW.
REQ-026 When reset is released and mem_ready=1 on the same edge, reset SHALL win; the first fetch is accepted no earlier than the next edge.

Configuration
REQ-027 With MUL_EN defined, mul (funct 011000) SHALL enter MULW:
- ALU=MUL held for MUL_CYCLES cycles by a down-counter.
- Then WB with reg_dst=1.
REQ-028 Without MUL_EN, MULW and its counter SHALL be absent and mul SHALL decode as illegal.

Verification
REQ-029 add $3,$1,$2 with mem_ready tied 1 -> FETCH,DECODE,EXEC,WB; reg_write=1, reg_dst=1, ALU=00000 in WB; pc_write only in the FETCH cycle.
REQ-030 lw with mem_ready low 3 cycles in MEM -> mem_req held 4 cycles, then WB with wb_sel=1; 8 cycles total.
REQ-031 beq with zero=1, then bne with zero=1 -> first: pc_write=1, pc_src=1 in BRANCH; second: no pc_write in BRANCH.
REQ-032 Opcode 111111 -> illegal pulses exactly 1 cycle in DECODE, no reg_write/mem_we, next state FETCH.
REQ-033 RESET_N low during MEM of sw with mem_req=1 -> mem_req and mem_we drop 0 asynchronously; after release, state FETCH.
REQ-034 mul with MUL_EN, MUL_CYCLES=4 -> 7 cycles fetch to fetch; without MUL_EN -> illegal=1.

Source files
------------

// File: rtl/mc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_sequencer_if
//  Description : Control/status bundle between the multi-cycle sequencer and
//                its datapath + memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mc_sequencer_if;
    logic [31:0] instruction;
    logic        zero;
    logic        alu_neg;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_we;
    logic        pc_write;
    logic        ir_write;
    logic        reg_write;
    logic [1:0]  pc_src;
    logic [1:0]  reg_dst;
    logic [1:0]  wb_sel;
    logic        alu_src_b;
    logic [4:0]  ALU;
    logic        illegal;

    modport master (
        input  instruction, zero, alu_neg, mem_ready,
        output mem_req, mem_we, pc_write, ir_write, reg_write,
               pc_src, reg_dst, wb_sel, alu_src_b, ALU, illegal
    );

    modport slave (
        output instruction, zero, alu_neg, mem_ready,
        input  mem_req, mem_we, pc_write, ir_write, reg_write,
               pc_src, reg_dst, wb_sel, alu_src_b, ALU, illegal
    );
endinterface
`default_nettype wire

// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mc_sequencer
//  Description : Multi-cycle MIPS-style control sequencer (FETCH..WB FSM).
//                Define MUL_EN to enable the multi-cycle MULW path.
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer #(
    parameter int MUL_CYCLES = 4
) (
    input  wire           CLOCK,
    input  wire           RESET_N,
    mc_sequencer_if.master bus
);

    localparam logic [4:0] c_alu_add = 5'b00000;
    localparam logic [4:0] c_alu_sll = 5'b00001;
    localparam logic [4:0] c_alu_sub = 5'b00010;
    localparam logic [4:0] c_alu_and = 5'b00011;
    localparam logic [4:0] c_alu_or  = 5'b00100;
    localparam logic [4:0] c_alu_nor = 5'b00101;
    localparam logic [4:0] c_alu_slt = 5'b00110;
    localparam logic [4:0] c_alu_srl = 5'b00111;
    localparam logic [4:0] c_alu_sra = 5'b01000;
    localparam logic [4:0] c_alu_lui = 5'b01010;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_regimm = 6'b000001;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_jal   = 6'b000011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_bgtz  = 6'b000111;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_addiu = 6'b001001;
    localparam logic [5:0] c_op_slti  = 6'b001010;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_lui   = 6'b001111;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;

    localparam logic [5:0] c_fn_sll  = 6'b000000;
    localparam logic [5:0] c_fn_srl  = 6'b000010;
    localparam logic [5:0] c_fn_sra  = 6'b000011;
    localparam logic [5:0] c_fn_jr   = 6'b001000;
    localparam logic [5:0] c_fn_add  = 6'b100000;
    localparam logic [5:0] c_fn_addu = 6'b100001;
    localparam logic [5:0] c_fn_sub  = 6'b100010;
    localparam logic [5:0] c_fn_subu = 6'b100011;
    localparam logic [5:0] c_fn_and  = 6'b100100;
    localparam logic [5:0] c_fn_or   = 6'b100101;
    localparam logic [5:0] c_fn_nor  = 6'b100111;
    localparam logic [5:0] c_fn_slt  = 6'b101010;
    localparam logic [5:0] c_fn_sltu = 6'b101011;

    localparam logic [2:0] c_cls_exec    = 3'd0;
    localparam logic [2:0] c_cls_branch  = 3'd1;
    localparam logic [2:0] c_cls_jump    = 3'd2;
    localparam logic [2:0] c_cls_mul     = 3'd3;
    localparam logic [2:0] c_cls_illegal = 3'd4;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_JUMP   = 3'd6
`ifdef MUL_EN
        , S_MULW = 3'd7
`endif
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;
    logic       r_nop;
    logic       r_armed;

    logic [2:0] w_cls;
    logic [4:0] w_alu;
    logic       w_imm;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_taken;
    logic       w_fetch_accept;

`ifdef MUL_EN
    localparam logic [5:0] c_fn_mul  = 6'b011000;
    localparam logic [4:0] c_alu_mul = 5'b01001;
    localparam logic [3:0] c_mul_load = 4'(MUL_CYCLES - 1);

    logic [3:0] r_mul_cnt;

    // Loaded in DECODE so MULW lasts exactly MUL_CYCLES cycles.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_mul_cnt <= 4'd0;
        end else if (r_state == S_DECODE) begin
            r_mul_cnt <= c_mul_load;
        end else if (r_state == S_MULW && r_mul_cnt != 4'd0) begin
            r_mul_cnt <= r_mul_cnt - 4'd1;
        end
    end
`else
    localparam logic [3:0] c_mul_load = 4'(MUL_CYCLES - 1);
    logic w_unused_mul;
    assign w_unused_mul = ^c_mul_load;
`endif

    // r_armed blocks fetch acceptance on the first edge after reset release.
    assign w_fetch_accept = (r_state == S_FETCH) && r_armed && bus.mem_ready;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state  <= S_FETCH;
            r_opcode <= 6'd0;
            r_funct  <= 6'd0;
            r_nop    <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_armed <= 1'b1;
            if (w_fetch_accept) begin
                r_opcode <= bus.instruction[31:26];
                r_funct  <= bus.instruction[5:0];
                r_nop    <= (bus.instruction == 32'd0);
            end
        end
    end

    always_comb begin
        w_cls   = c_cls_illegal;
        w_alu   = c_alu_add;
        w_imm   = 1'b0;
        w_is_lw = 1'b0;
        w_is_sw = 1'b0;
        case (r_opcode)
            c_op_rtype: begin
                w_cls = c_cls_exec;
                case (r_funct)
                    c_fn_sll:            w_alu = c_alu_sll;
                    c_fn_srl:            w_alu = c_alu_srl;
                    c_fn_sra:            w_alu = c_alu_sra;
                    c_fn_add, c_fn_addu: w_alu = c_alu_add;
                    c_fn_sub, c_fn_subu: w_alu = c_alu_sub;
                    c_fn_and:            w_alu = c_alu_and;
                    c_fn_or:             w_alu = c_alu_or;
                    c_fn_nor:            w_alu = c_alu_nor;
                    c_fn_slt, c_fn_sltu: w_alu = c_alu_slt;
                    c_fn_jr:             w_cls = c_cls_jump;
`ifdef MUL_EN
                    c_fn_mul: begin
                        w_cls = c_cls_mul;
                        w_alu = c_alu_mul;
                    end
`endif
                    default:             w_cls = c_cls_illegal;
                endcase
            end
            c_op_addi, c_op_addiu: begin
                w_cls = c_cls_exec;
                w_imm = 1'b1;
            end
            c_op_slti: begin
                w_cls = c_cls_exec;
                w_imm = 1'b1;
                w_alu = c_alu_slt;
            end
            c_op_andi: begin
                w_cls = c_cls_exec;
                w_imm = 1'b1;
                w_alu = c_alu_and;
            end
            c_op_ori: begin
                w_cls = c_cls_exec;
                w_imm = 1'b1;
                w_alu = c_alu_or;
            end
            c_op_lui: begin
                w_cls = c_cls_exec;
                w_imm = 1'b1;
                w_alu = c_alu_lui;
            end
            c_op_lw: begin
                w_cls   = c_cls_exec;
                w_imm   = 1'b1;
                w_is_lw = 1'b1;
            end
            c_op_sw: begin
                w_cls   = c_cls_exec;
                w_imm   = 1'b1;
                w_is_sw = 1'b1;
            end
            c_op_beq, c_op_bne, c_op_regimm, c_op_bgtz: w_cls = c_cls_branch;
            c_op_j, c_op_jal:                           w_cls = c_cls_jump;
            default:                                    w_cls = c_cls_illegal;
        endcase
    end

    always_comb begin
        case (r_opcode)
            c_op_beq:    w_taken = bus.zero;
            c_op_bne:    w_taken = !bus.zero;
            c_op_regimm: w_taken = !bus.alu_neg;
            c_op_bgtz:   w_taken = !bus.alu_neg && !bus.zero;
            default:     w_taken = 1'b0;
        endcase
    end

    // Outputs are forced low combinationally while RESET_N is asserted.
    always_comb begin
        w_state_next  = r_state;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.pc_write  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.reg_write = 1'b0;
        bus.pc_src    = 2'd0;
        bus.reg_dst   = 2'd0;
        bus.wb_sel    = 2'd0;
        bus.alu_src_b = 1'b0;
        bus.ALU       = 5'd0;
        bus.illegal   = 1'b0;
        if (RESET_N) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_req = r_armed;
                    if (w_fetch_accept) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        w_state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (w_cls)
                        c_cls_exec:   w_state_next = S_EXEC;
                        c_cls_branch: w_state_next = S_BRANCH;
                        c_cls_jump:   w_state_next = S_JUMP;
`ifdef MUL_EN
                        c_cls_mul:    w_state_next = S_MULW;
`endif
                        default: begin
                            bus.illegal  = 1'b1;
                            w_state_next = S_FETCH;
                        end
                    endcase
                end
                S_EXEC: begin
                    bus.ALU       = w_alu;
                    bus.alu_src_b = w_imm;
                    w_state_next  = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = w_is_sw;
                    if (bus.mem_ready) begin
                        w_state_next = w_is_sw ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    bus.reg_write = !r_nop;
                    bus.reg_dst   = (r_opcode == c_op_rtype) ? 2'd1 : 2'd0;
                    bus.wb_sel    = w_is_lw ? 2'd1 : 2'd0;
                    w_state_next  = S_FETCH;
                end
                S_BRANCH: begin
                    bus.ALU = c_alu_sub;
                    if (w_taken) begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'd1;
                    end
                    w_state_next = S_FETCH;
                end
                S_JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pc_src   = (r_opcode == c_op_rtype) ? 2'd3 : 2'd2;
                    if (r_opcode == c_op_jal) begin
                        bus.reg_write = 1'b1;
                        bus.reg_dst   = 2'd2;
                        bus.wb_sel    = 2'd2;
                    end
                    w_state_next = S_FETCH;
                end
`ifdef MUL_EN
                S_MULW: begin
                    bus.ALU = c_alu_mul;
                    if (r_mul_cnt == 4'd0) begin
                        w_state_next = S_WB;
                    end
                end
`endif
                default: w_state_next = S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire
